// File: rtl/audio_fir_decim.sv
// audio_fir_decim: decimating low-pass FIR, one time-multiplexed MAC per output.
// Define AUDIO_FIR_DECIM_SAT_EN to clamp the result to the signed 16-bit range.
module audio_fir_decim #(
  parameter int TAPS      = 32,
  parameter int DECIM     = 8,
  parameter int FRAC_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_empty,
  output logic        in_rd_en,
  input  logic [31:0] x_in,
  output logic [31:0] y_out,
  output logic        out_wr_en,
  input  logic        out_full
);
  localparam int CW = $clog2(DECIM + 1);
  localparam int TW = $clog2(TAPS);
  localparam logic signed [31:0] RND  = 32'((1 << FRAC_BITS) - 1);
  localparam logic signed [31:0] SMAX = 32'sd32767;
  localparam logic signed [31:0] SMIN = -32'sd32768;
  localparam logic signed [31:0] COEFF [TAPS] = '{
    32'sd3,    -32'sd7,   -32'sd12,  -32'sd500, 32'sd9,    32'sd21,   32'sd38,   32'sd56,
    32'sd60,   32'sd41,   -32'sd11,  -32'sd84,  32'sd130,  32'sd290,  32'sd410,  32'sd460,
    32'sd460,  32'sd410,  32'sd290,  32'sd130,  -32'sd84,  -32'sd11,  32'sd41,   32'sd60,
    32'sd56,   32'sd38,   32'sd21,   32'sd9,    -32'sd500, -32'sd12,  -32'sd7,   32'sd3
  };
  typedef enum logic [1:0] {LOAD, MAC, OUTPUT} state_t;
  state_t             r_state, w_next;
  logic [CW-1:0]      r_load_cnt;
  logic [TW-1:0]      r_tap_idx;
  logic signed [31:0] r_acc, r_result;
  logic signed [31:0] r_hist [TAPS];
  logic               w_pop, w_last_pop, w_mac, w_last_tap;
  logic signed [31:0] w_prod, w_bias, w_deq, w_sum, w_res;
  assign w_pop      = (r_state == LOAD) && !in_empty && !reset;
  assign w_last_pop = w_pop && (r_load_cnt == CW'(DECIM - 1));
  assign w_mac      = (r_state == MAC);
  assign w_last_tap = w_mac && (r_tap_idx == TW'(TAPS - 1));
  assign in_rd_en   = w_pop;
  assign out_wr_en  = (r_state == OUTPUT) && !out_full;
  assign y_out      = r_result;
  // Only the low 32 bits of the product matter, so a 32-bit multiply suffices.
  assign w_prod = COEFF[r_tap_idx] * r_hist[r_tap_idx];
  assign w_bias = w_prod[31] ? w_prod + RND : w_prod;
  assign w_deq  = w_bias >>> FRAC_BITS;
  assign w_sum  = r_acc + w_deq;
`ifdef AUDIO_FIR_DECIM_SAT_EN
  assign w_res = (w_sum > SMAX) ? SMAX : (w_sum < SMIN) ? SMIN : w_sum;
`else
  assign w_res = w_sum;
`endif
  always_comb begin
    w_next = r_state;
    w_next = w_last_pop ? MAC :
             w_last_tap ? OUTPUT :
             ((r_state == OUTPUT) && !out_full) ? LOAD : r_state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= LOAD;
      r_load_cnt <= '0;
      r_tap_idx  <= '0;
      r_acc      <= '0;
      r_result   <= '0;
    end else begin
      r_state <= w_next;
      if (w_pop) r_load_cnt <= w_last_pop ? '0 : r_load_cnt + CW'(1);
      if (w_mac) r_tap_idx <= w_last_tap ? '0 : r_tap_idx + TW'(1);
      if (w_last_pop) r_acc <= '0;
      else if (w_mac) r_acc <= w_sum;
      if (w_last_tap) r_result <= w_res;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) r_hist[k] <= '0;
    end else if (w_pop) begin
      r_hist[0] <= $signed(x_in);
      for (int k = 1; k < TAPS; k++) r_hist[k] <= r_hist[k-1];
    end
  end
endmodule

// File: tb/tb_audio_fir_decim.sv
// tb_audio_fir_decim: scoreboard bench for audio_fir_decim.
// Expected outputs come from a behavioral FIR model fed by observed pops.
module tb_audio_fir_decim;
  logic        clk = 0, reset, in_empty, in_rd_en, out_wr_en, out_full;
  logic [31:0] x_in, y_out;
  audio_fir_decim dut (
    .clk(clk), .reset(reset), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .x_in(x_in), .y_out(y_out), .out_wr_en(out_wr_en), .out_full(out_full)
  );
  always #5 clk = ~clk;
  typedef struct packed {int v; int t;} exp_t;
  int tc [32] = '{3, -7, -12, -500, 9, 21, 38, 56, 60, 41, -11, -84, 130, 290, 410, 460,
                  460, 410, 290, 130, -84, -11, 41, 60, 56, 38, 21, 9, -500, -12, -7, 3};
  int   mh [32];
  int   src [$];
  int   got_q [$];
  exp_t exp_q [$];
  int   n_chk = 0, n_err = 0, n_rd = 0, n_wr = 0, cyc_n = 0, pc = 0, dc_sum = 0;
  bit   rnd_empty = 0, full_force = 0, lat_skip = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask
  function automatic int fir_out();
    int acc = 0;
    for (int i = 0; i < 32; i++) begin
      longint p = longint'(tc[i]) * longint'(mh[i]);
      int lo = int'(p);
      acc += (lo < 0 ? lo + 1023 : lo) >>> 10;
    end
`ifdef AUDIO_FIR_DECIM_SAT_EN
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
`endif
    return acc;
  endfunction
  task automatic model_pop(input int x);
    for (int k = 31; k > 0; k--) mh[k] = mh[k-1];
    mh[0] = x;
    if (++pc == 8) begin
      pc = 0;
      exp_q.push_back('{v: fir_out(), t: cyc_n});
    end
  endtask
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    x_in     = (src.size() != 0) ? src[0] : 32'd0;
    in_empty = (src.size() == 0) || (rnd_empty && $urandom_range(0, 1) == 1);
    out_full = full_force;
    #2;
    if (in_rd_en && out_wr_en) chk("rd_wr_exclusive", 1, 0);
    if (in_rd_en) begin
      model_pop(src.pop_front());
      n_rd++;
    end
    if (out_wr_en) begin
      n_wr++;
      if (exp_q.size() == 0) chk("spurious_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("y_out", y_out, e.v);
        if (!lat_skip) chk("latency", cyc_n - e.t, 33);
        lat_skip = 0;
        got_q.push_back(y_out);
      end
    end
    cyc_n++;
  endtask
  task automatic do_reset();
    reset = 1;
    src.delete();
    exp_q.delete();
    got_q.delete();
    for (int k = 0; k < 32; k++) mh[k] = 0;
    pc = 0;
    in_empty = 1;
    out_full = 0;
    repeat (3) @(negedge clk);
    reset = 0;
  endtask
  task automatic drain(input int bound);
    int n = 0;
    while ((src.size() != 0 || exp_q.size() != 0) && n < bound) begin
      cyc();
      n++;
    end
    if (n >= bound) chk("drain_timeout", 0, 1);
  endtask
  task automatic impulse(input string tag, input int bound);
    got_q.delete();
    src.push_back(1024);
    repeat (39) src.push_back(0);
    drain(bound);
    chk({tag, "_count"}, got_q.size(), 5);
    if (got_q.size() == 5) begin
      chk({tag, "_0"}, got_q[0], tc[7]);
      chk({tag, "_1"}, got_q[1], tc[15]);
      chk({tag, "_2"}, got_q[2], tc[23]);
      chk({tag, "_3"}, got_q[3], tc[31]);
      chk({tag, "_4"}, got_q[4], 0);
    end
  endtask
  task automatic dc_run(input string tag, input int x, input int want);
    got_q.delete();
    repeat (48) src.push_back(x);
    drain(400);
    chk({tag, "_count"}, got_q.size(), 6);
    for (int i = 3; i < got_q.size(); i++) chk(tag, got_q[i], want);
  endtask
  initial begin
    int w0, r0, n;
    foreach (tc[i]) dc_sum += tc[i];
    reset = 1; in_empty = 0; out_full = 0; x_in = 32'd5;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_in_rd_en", in_rd_en, 0);
    chk("rst_out_wr_en", out_wr_en, 0);
    chk("rst_y_out", y_out, 0);
    do_reset();
    impulse("impulse", 400);
    dc_run("dc", 1024, dc_sum);
    do_reset();
    got_q.delete();
    src = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0};
    drain(200);
    chk("round_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("round_neg500", got_q[0], 0);
      chk("round_pos500", got_q[1], 0);
    end
    do_reset();
    rnd_empty = 1;
    impulse("empty_toggle", 1200);
    rnd_empty = 0;
    full_force = 1;
    lat_skip = 1;
    repeat (8) src.push_back(int'($urandom_range(0, 8191)) - 4096);
    repeat (45) cyc();
    w0 = n_wr; r0 = n_rd;
    repeat (10) begin
      cyc();
      chk("bp_y_hold", y_out, (exp_q.size() != 0) ? exp_q[0].v : 32'hdead_beef);
      chk("bp_wr_low", out_wr_en, 0);
      chk("bp_rd_low", in_rd_en, 0);
    end
    chk("bp_no_write", n_wr - w0, 0);
    chk("bp_no_pop", n_rd - r0, 0);
    full_force = 0;
    repeat (3) cyc();
    chk("bp_one_write", n_wr - w0, 1);
    r0 = n_rd;
    repeat (8) src.push_back(int'($urandom_range(1, 8191)));
    n = 0;
    while (n_rd - r0 < 8 && n < 50) begin
      cyc();
      n++;
    end
    if (n >= 50) chk("mac_pop_timeout", 0, 1);
    repeat (12) cyc();
    @(posedge clk);
    #2;
    reset = 1;
    #1;
    chk("midmac_in_rd_en", in_rd_en, 0);
    chk("midmac_out_wr_en", out_wr_en, 0);
    chk("midmac_y_out", y_out, 0);
    do_reset();
    w0 = n_wr;
    repeat (50) cyc();
    chk("midmac_no_write", n_wr - w0, 0);
    impulse("post_reset_impulse", 400);
    do_reset();
`ifdef AUDIO_FIR_DECIM_SAT_EN
    dc_run("sat", 23 * 1024, 32767);
`else
    dc_run("sat", 23 * 1024, 41584);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
